// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
// Multi-cycle load/store unit placed after the execute stage. Accepts one
// memory op at a time, issues a single valid/ready request to memory, waits
// for the response and presents one write-back result.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   op handshake from exe (ready only in IDLE)
//   is_load_i, is_store_i   op type (both set -> load)
//   funct3_i                access size/sign: B, H, W, BU, HU
//   addr_i, wdata_i, rd_i   effective address, store data, load destination
//   mem_req_*               word-aligned request with byte-lane data/strobes
//   mem_rsp_*               read data or write acknowledge
//   wb_*                    write-back result, held until wb_ready_i
module lsu_mem_stage #(
  parameter int XLEN = 32,
  parameter int RS_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RS_W-1:0] rd_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_wstrb_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_data_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic            wb_wen_o,
  output logic [RS_W-1:0] wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            wb_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] rsp_data_reg;
  logic [2:0]      funct3_reg;
  logic [RS_W-1:0] rd_reg;
  logic            is_load_reg;
  logic            misalign_reg;

  logic            accept;
  logic            misalign_in;
  logic [1:0]      off;
  logic            is_byte;
  logic            is_half;
  logic [XLEN-1:0] lane_wdata;
  logic [3:0]      lane_strb;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_ext;
  logic            in_req;
  logic            in_resp;
  logic            wb_load_ok;

  // Ops with neither load nor store set are not memory ops and are dropped.
  assign accept = (state_reg == IDLE) && in_valid_i && (is_load_i || is_store_i);

  // funct3[1:0]: 00 byte, 01 half, 1x word (undefined encodings fall into word).
  assign misalign_in = (funct3_i[1:0] == 2'b01) ? addr_i[0] :
                       funct3_i[1]              ? (addr_i[1:0] != 2'b00) : 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rsp_data_reg <= '0;
      funct3_reg   <= '0;
      rd_reg       <= '0;
      is_load_reg  <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg     <= addr_i;
        wdata_reg    <= wdata_i;
        funct3_reg   <= funct3_i;
        rd_reg       <= rd_i;
        is_load_reg  <= is_load_i;
        misalign_reg <= misalign_in;
      end
      if ((state_reg == WAIT) && mem_rsp_valid_i) begin
        rsp_data_reg <= mem_rsp_data_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = misalign_in ? RESP : REQ;
      REQ:  if (mem_req_ready_i) state_next = WAIT;
      // A response coincident with the request handshake is seen in REQ and
      // therefore never consumed; only WAIT listens to mem_rsp_valid_i.
      WAIT: if (mem_rsp_valid_i) state_next = RESP;
      RESP: if (wb_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lane shaping: each byte lane picks its source byte and strobe.
  assign off     = addr_reg[1:0];
  assign is_byte = (funct3_reg[1:0] == 2'b00);
  assign is_half = (funct3_reg[1:0] == 2'b01);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_wdata[gi*8 +: 8] = is_byte ? wdata_reg[7:0] :
                                     is_half ? wdata_reg[(gi%2)*8 +: 8] :
                                               wdata_reg[gi*8 +: 8];
      assign lane_strb[gi] = is_byte ? (off == 2'(gi)) :
                             is_half ? (off[1] == 1'(gi/2)) : 1'b1;
    end
  endgenerate

  // Load extraction; half accesses are aligned so off[0] is always 0 there.
  assign load_byte = rsp_data_reg[{off, 3'b000} +: 8];
  assign load_half = rsp_data_reg[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = rsp_data_reg;
    case (funct3_reg)
      3'b000:  load_ext = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, load_byte};
      3'b001:  load_ext = {{(XLEN-16){load_half[15]}}, load_half};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_half};
      default: load_ext = rsp_data_reg;
    endcase
  end

  // Outputs are gated by state so everything idles at zero outside its phase.
  assign in_req     = (state_reg == REQ);
  assign in_resp    = (state_reg == RESP);
  assign wb_load_ok = in_resp && is_load_reg && !misalign_reg;

  assign in_ready_o      = (state_reg == IDLE);
  assign mem_req_valid_o = in_req;
  assign mem_we_o        = in_req && !is_load_reg;
  assign mem_addr_o      = in_req ? {addr_reg[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata_o     = (in_req && !is_load_reg) ? lane_wdata : '0;
  assign mem_wstrb_o     = (in_req && !is_load_reg) ? lane_strb : 4'b0000;

  assign wb_valid_o    = in_resp;
  assign wb_wen_o      = wb_load_ok && (rd_reg != '0);
  assign wb_rd_o       = in_resp ? rd_reg : '0;
  assign wb_data_o     = wb_load_ok ? load_ext : '0;
  assign wb_misalign_o = in_resp && misalign_reg;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        wb_wen_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_misalign_o;

  lsu_mem_stage #(.XLEN(32), .RS_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .wb_wen_o(wb_wen_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .wb_misalign_o(wb_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic        misalign;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_rd;
    int          lat;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int req_stall = 0;
  int rsp_delay = 0;
  int wb_stall = 0;
  int accept_cyc = 0;
  int req_count = 0;
  int wb_done = 0;
  bit in_wait = 0;
  logic [31:0] rsp_word = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: checks each request against the scoreboard, optionally
  // stalls ready, then returns one response after rsp_delay cycles.
  initial begin
    req_exp_t r;
    bit aborted;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i || !mem_req_valid_o) continue;
      req_count++;
      if (req_q.size() == 0) begin
        check("req_unexpected", 64'(mem_req_valid_o), 64'd0);
        r = '{we: 1'b0, addr: '0, wdata: '0, wstrb: '0};
      end else begin
        r = req_q.pop_front();
      end
      $display("req  we=%0b addr=0x%08h wdata=0x%08h wstrb=%04b", mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
      check("req_we", 64'(mem_we_o), 64'(r.we));
      check("req_addr", 64'(mem_addr_o), 64'(r.addr));
      if (r.we) begin
        check("req_wdata", 64'(mem_wdata_o), 64'(r.wdata));
        check("req_wstrb", 64'(mem_wstrb_o), 64'(r.wstrb));
      end
      for (int i = 0; i < req_stall; i++) begin
        @(negedge clk_i);
        check("req_hold_valid", 64'(mem_req_valid_o), 64'd1);
        check("req_hold_addr", 64'(mem_addr_o), 64'(r.addr));
        check("req_hold_we", 64'(mem_we_o), 64'(r.we));
        if (r.we) begin
          check("req_hold_wdata", 64'(mem_wdata_o), 64'(r.wdata));
          check("req_hold_wstrb", 64'(mem_wstrb_o), 64'(r.wstrb));
        end
        check("in_ready_in_req", 64'(in_ready_o), 64'd0);
      end
      mem_req_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      mem_req_ready_i = 1'b0;
      in_wait = 1'b1;
      aborted = 1'b0;
      for (int i = 0; i < rsp_delay; i++) begin
        @(posedge clk_i);
        #1;
        if (rst_i) begin
          aborted = 1'b1;
          break;
        end
        check("in_ready_in_wait", 64'(in_ready_o), 64'd0);
      end
      if (aborted) begin
        in_wait = 1'b0;
        while (rst_i) @(negedge clk_i);
        // Stray response after the abandoned op.
        @(posedge clk_i);
        #1;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h1234_5678;
        @(posedge clk_i);
        #1;
        mem_rsp_valid_i = 1'b0;
        continue;
      end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = rsp_word;
      @(posedge clk_i);
      #1;
      mem_rsp_valid_i = 1'b0;
      in_wait = 1'b0;
    end
  end

  // Write-back consumer: pops the scoreboard on the first wb_valid cycle and
  // verifies the result stays stable through wb_stall cycles of backpressure.
  initial begin
    wb_exp_t e;
    wb_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i || !wb_valid_o) continue;
      if (wb_q.size() == 0) begin
        check("wb_unexpected", 64'(wb_valid_o), 64'd0);
        e = '{misalign: 1'b0, wen: 1'b0, rd: '0, data: '0, chk_rd: 1'b0, lat: 0};
      end else begin
        e = wb_q.pop_front();
      end
      if (e.lat > 0) check("wb_latency", 64'(cyc - accept_cyc), 64'(e.lat));
      for (int i = 0; ; i++) begin
        check("wb_misalign", 64'(wb_misalign_o), 64'(e.misalign));
        check("wb_wen", 64'(wb_wen_o), 64'(e.wen));
        check("wb_data", 64'(wb_data_o), 64'(e.data));
        if (e.chk_rd) check("wb_rd", 64'(wb_rd_o), 64'(e.rd));
        check("in_ready_in_resp", 64'(in_ready_o), 64'd0);
        if (i >= wb_stall) break;
        @(negedge clk_i);
        check("wb_hold_valid", 64'(wb_valid_o), 64'd1);
      end
      $display("wb   rd=%0d wen=%0b misalign=%0b data=0x%08h", wb_rd_o, wb_wen_o, wb_misalign_o, wb_data_o);
      wb_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      wb_ready_i = 1'b0;
      wb_done++;
    end
  end

  // Drives one op, pushes the expected request/result, optionally waits for it.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] rsp,
                       input int lat, input bit wait_done);
    int       size;
    int       off;
    logic     mis;
    logic     is_ld;
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    req_exp_t r;
    wb_exp_t  e;
    int t;
    int done0;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      default:        size = 4;
    endcase
    off   = int'(addr[1:0]);
    mis   = (off % size) != 0;
    is_ld = ld;
    if (!mis) begin
      r.we   = !is_ld;
      r.addr = addr & 32'hFFFF_FFFC;
      case (size)
        1:       begin r.wstrb = 4'(1 << off); r.wdata = {4{wdata[7:0]}}; end
        2:       begin r.wstrb = 4'(3 << off); r.wdata = {2{wdata[15:0]}}; end
        default: begin r.wstrb = 4'hF;         r.wdata = wdata; end
      endcase
      req_q.push_back(r);
    end
    sh = rsp >> (8 * off);
    b  = sh[7:0];
    h  = sh[15:0];
    e.misalign = mis;
    e.wen      = is_ld && !mis && (rd != 0);
    e.rd       = rd;
    e.chk_rd   = is_ld && !mis;
    e.lat      = lat;
    e.data     = '0;
    if (is_ld && !mis) begin
      case (f3)
        3'b000:  e.data = 32'($signed(b));
        3'b100:  e.data = {24'd0, b};
        3'b001:  e.data = 32'($signed(h));
        3'b101:  e.data = {16'd0, h};
        default: e.data = rsp;
      endcase
    end
    wb_q.push_back(e);
    done0 = wb_done;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b1;
    is_load_i  = ld;
    is_store_i = st;
    funct3_i   = f3;
    addr_i     = addr;
    wdata_i    = wdata;
    rd_i       = rd;
    rsp_word   = rsp;
    t = 0;
    @(negedge clk_i);
    while (!in_ready_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    check("in_ready_accept", 64'(in_ready_o), 64'd1);
    accept_cyc = cyc;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    is_load_i  = 1'b0;
    is_store_i = 1'b0;
    if (wait_done) begin
      t = 0;
      while (wb_done == done0 && t < 200) begin
        @(negedge clk_i);
        t++;
      end
      check("wb_done", 64'(wb_done - done0), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int reqs0;
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    is_load_i  = 1'b0;
    is_store_i = 1'b0;
    funct3_i   = '0;
    addr_i     = '0;
    wdata_i    = '0;
    rd_i       = '0;
    repeat (2) @(negedge clk_i);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_we", 64'(mem_we_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_wstrb", 64'(mem_wstrb_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_wb_data", 64'(wb_data_o), 64'd0);
    check("rst_wb_misalign", 64'(wb_misalign_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // LB with sign extension, minimum latency
    do_op(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd3, 32'h80AA_BBCC, 3, 1);
    // SH to upper half
    do_op(0, 1, 3'b001, 32'h8000_0002, 32'h1234_5678, 5'd0, 32'h0, 0, 1);
    // Misaligned LW: no memory request, result the next cycle
    reqs0 = req_count;
    do_op(1, 0, 3'b010, 32'h8000_0001, 32'h0, 5'd5, 32'h0, 1, 1);
    check("misalign_no_req", 64'(req_count - reqs0), 64'd0);
    // Backpressure everywhere, LHU at offset 2
    req_stall = 5; rsp_delay = 3; wb_stall = 2;
    do_op(1, 0, 3'b101, 32'h8000_0002, 32'h0, 5'd7, 32'hFFFF_1234, 0, 1);
    req_stall = 0; rsp_delay = 0; wb_stall = 0;
    @(negedge clk_i);
    check("in_ready_after_wb", 64'(in_ready_o), 64'd1);

    // Reset while waiting for the response
    rsp_delay = 50;
    do_op(1, 0, 3'b010, 32'h8000_0004, 32'h0, 5'd4, 32'hAAAA_AAAA, 0, 0);
    t = 0;
    while (!in_wait && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    check("reached_wait", 64'(in_wait), 64'd1);
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    wb_q.delete();
    @(negedge clk_i);
    check("midrst_in_ready", 64'(in_ready_o), 64'd1);
    check("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    rsp_delay = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("stray_wb_valid", 64'(wb_valid_o), 64'd0);
      check("stray_in_ready", 64'(in_ready_o), 64'd1);
    end

    // LW to x0: access happens but no register write
    reqs0 = req_count;
    do_op(1, 0, 3'b010, 32'h8000_0008, 32'h0, 5'd0, 32'hDEAD_BEEF, 3, 1);
    check("rd0_req_done", 64'(req_count - reqs0), 64'd1);
    // Assorted sizes, signs and offsets
    do_op(1, 0, 3'b100, 32'h8000_0001, 32'h0, 5'd9, 32'h0000_F100, 0, 1);
    do_op(1, 0, 3'b001, 32'h8000_0000, 32'h0, 5'd10, 32'h0000_8001, 0, 1);
    do_op(0, 1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 5'd0, 32'h0, 0, 1);
    do_op(0, 1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 1);
    do_op(1, 0, 3'b001, 32'h8000_0003, 32'h0, 5'd11, 32'h0, 1, 1);
    // Undefined funct3 follows word rules
    do_op(1, 0, 3'b011, 32'h8000_0002, 32'h0, 5'd12, 32'h0, 1, 1);
    do_op(1, 0, 3'b110, 32'h8000_0020, 32'h0, 5'd13, 32'h0BAD_F00D, 0, 1);
    // Load and store both set: treated as load
    do_op(1, 1, 3'b000, 32'h8000_0002, 32'h0000_0055, 5'd14, 32'h0011_2233, 0, 1);

    // in_valid with neither load nor store is ignored
    reqs0 = req_count;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b1;
    funct3_i   = 3'b010;
    addr_i     = 32'h8000_0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("nop_in_ready", 64'(in_ready_o), 64'd1);
      check("nop_wb_valid", 64'(wb_valid_o), 64'd0);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("nop_no_req", 64'(req_count - reqs0), 64'd0);
    check("queues_empty", 64'(wb_q.size() + req_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Multi-cycle load/store unit sitting directly downstream of the execute stage.
- Consumes the effective address from exe plus decoded load/store info; produces write-back data for the register file.
- Replaces the single-cycle combinational data access with a valid/ready memory handshake.
- Handles byte-lane alignment, write strobes, load sign/zero extension and misalignment detection.

Parameters:
- XLEN, 32, data and address width.
- RS_W, 5, register index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  exe presents a memory op
- in_ready_o  out  1  LSU can accept an op
- is_load_i  in  1  op is a load
- is_store_i  in  1  op is a store
- funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  XLEN  effective address (exe res)
- wdata_i  in  XLEN  store data (src2)
- rd_i  in  RS_W  load destination
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  XLEN  word-aligned address (addr[1:0] forced 0)
- mem_wdata_o  out  XLEN  store data shifted to byte lane
- mem_wstrb_o  out  4  byte write strobes
- mem_rsp_valid_i  in  1  response valid (read data or write ack)
- mem_rsp_data_i  in  XLEN  read word
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  write-back consumes result
- wb_wen_o  out  1  register write enable (loads only, rd≠0, no error)
- wb_rd_o  out  RS_W  destination register
- wb_data_o  out  XLEN  extended load data
- wb_misalign_o  out  1  misaligned access flagged

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset (async, rst_i=1) forces:
  - state IDLE;
  - all outputs 0 except in_ready_o=1;
  - all captured registers 0.
- Reset asserted mid-transaction abandons the op. No response is held; a late mem_rsp_valid_i after reset is ignored in IDLE.
- IDLE:
  - in_ready_o=1.
  - Accept on in_valid_i && (is_load_i || is_store_i); register addr, wdata, funct3, rd, load/store type.
  - in_valid_i with neither load nor store set is ignored (not accepted).
  - If is_load_i and is_store_i are both 1, treat as load.
- Misalignment, checked at accept:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=0.
  - Misaligned op goes IDLE→RESP directly with no memory request: wb_misalign_o=1, wb_wen_o=0, wb_data_o=0.
- REQ:
  - mem_req_valid_o=1, registered one cycle after accept.
  - Hold addr/we/wdata/wstrb stable until mem_req_ready_i; then go to WAIT.
  - mem_rsp_valid_i in the same cycle as handshake is not consumed; the response arrives earliest the next cycle.
- WAIT:
  - On mem_rsp_valid_i, capture mem_rsp_data_i (loads) and go to RESP.
  - Stays indefinitely; no timeout.
- RESP:
  - wb_valid_o=1; outputs held stable until wb_ready_i.
  - Then go to IDLE; in_ready_o rises the following cycle (no same-cycle re-accept).
- in_ready_o=1 only in IDLE.
- Minimum accepted-op latency with ready memory and ready wb: accept cycle 0, req cycle 1, rsp cycle 2, wb_valid cycle 3.
- Store lane shaping, off = addr[1:0]:
  - SB: wstrb = 0001<<off; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<off; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata unchanged.
- Load extraction:
  - byte = rsp>>(8*off), low 8 bits; half = rsp>>(8*off), low 16 bits.
  - B sign-extends, BU zero-extends; H sign-extends, HU zero-extends; W passes through.
- Write-back enables:
  - wb_wen_o = load && !misalign && rd≠0.
  - Stores produce wb_valid_o with wb_wen_o=0 and wb_data_o=0.
- Undefined funct3 (011, 110, 111) behaves as W with the W alignment rule.

Test Plan:
- LB addr=0x8000_0003, rsp_data=0x80AA_BBCC, always-ready memory → mem_addr=0x8000_0000, wb_valid at cycle 3, wb_data=0xFFFF_FF80, wb_wen=1.
- SH addr=0x8000_0002, wdata=0x1234_5678 → mem_we=1, wstrb=1100, mem_wdata=0x5678_5678; wb_valid with wb_wen=0.
- LW addr=0x8000_0001 → no mem_req_valid ever; wb_valid next cycle, wb_misalign=1, wb_wen=0.
- mem_req_ready low 5 cycles, rsp delayed 3 cycles, wb_ready low 2 cycles → request fields stable throughout, in_ready=0 until return to IDLE, LHU of 0xFFFF at offset 2 yields 0x0000_FFFF.
- rst_i pulsed while in WAIT, then stray mem_rsp_valid → state IDLE, wb_valid stays 0, in_ready=1.
- LW to rd=0 → memory access performed, wb_valid=1, wb_wen=0.
